alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 instr_valid  in  1  instruction word offered.
REQ-004 instr_ready  out  1  block can accept an instruction.
REQ-005 instr  in  13  [12:10] op, [9:8] rd, [7:6] rs1, [5:4] rs2, [3:0] imm.
REQ-006 alu_a  out  4  operand A to the downstream 4-bit ALU.
REQ-007 alu_b  out  4  operand B to the ALU.
REQ-008 alu_sel  out  3  ALU operation select (000 add, 001 sub, 010 and, 011 or, 100 xor).
REQ-009 alu_out  in  4  combinational ALU result, valid in the same cycle as alu_a/alu_b/alu_sel.
REQ-010 res_valid  out  1  result offered.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 res_data  out  4  result value.
REQ-013 res_rd  out  2  destination register of result.
REQ-014 res_zero  out  1  res_data == 0.
REQ-015 res_err  out  1  illegal opcode flag.
REQ-016 instr_count  out  8  completed-instruction counter.

Function
REQ-017 Block SHALL contain a 4-entry x 4-bit register file R0..R3.
REQ-018 FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on instr_valid & instr_ready; EXEC->RESP unconditionally after one cycle; RESP->IDLE on res_valid & res_ready.
REQ-019 instr_ready SHALL be 1 only in IDLE; the instruction word SHALL be latched on the accepting edge.
REQ-020 In EXEC, op 000-100: alu_a = R[rs1], alu_b = R[rs2], alu_sel = op.
REQ-021 In EXEC, op 101 (LOADI): alu_a = 0, alu_b = imm, alu_sel = 000.
REQ-022 In EXEC, op 110/111 (illegal): alu_a = 0, alu_b = 0, alu_sel = 000; result forced to 0 and res_err = 1.
REQ-023 Outside EXEC, alu_a, alu_b and alu_sel SHALL be 0.
REQ-024 On the EXEC->RESP edge: the result register SHALL capture alu_out (or 0 if illegal). R[rd] SHALL be written with that value for legal ops only.
REQ-025 Arithmetic is modulo 16; no carry or borrow is reported (e.g. 9+8 -> 1, 2-3 -> F).
REQ-026 In RESP: res_valid = 1; res_data, res_rd, res_zero and res_err SHALL be held stable until the handshake.
REQ-027 res_ready already high on RESP entry SHALL give exactly one res_valid cycle; minimum issue interval is 3 cycles.
REQ-028 instr_count SHALL increment by 1 on each result handshake and wrap 255 -> 0.
REQ-029 The operand read for an instruction SHALL observe all writes from previous instructions (sequential, no hazards).

Reset
REQ-030 rst high SHALL immediately force: state IDLE, R0..R3 = 0, result register 0, res_valid 0, res_err 0, res_zero 0, res_rd 0, instr_count 0, ALU outputs 0.
REQ-031 After rst deasserts, instr_ready SHALL be 1 on the first clock.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the instruction with no register write and no count increment.

Verification
REQ-033 LOADI R1,5; LOADI R2,3; ADD R0=R1+R2 -> res_data 8, res_rd 0, res_zero 0, instr_count 3.
REQ-034 SUB R3 = R2-R1 (3-5) -> res_data E; XOR R0 = R1^R1 -> res_data 0, res_zero 1.
REQ-035 Opcode 110 with rd=1 -> res_err 1, res_data 0; R1 unchanged at 5 on later read.
REQ-036 Hold res_ready low for 4 cycles in RESP -> res_valid and res_data stable, instr_ready 0 throughout; then one handshake.
REQ-037 Assert rst during EXEC of ADD -> all outputs 0 asynchronously, R0..R3 = 0, instr_count 0.
REQ-038 Issue 256 LOADI with res_ready held high -> instr_count wraps to 0; back-to-back issue every 3 cycles.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 4-bit ALU: decodes one instruction, drives the external ALU, writes back to R0..R3.
// Latency: accept -> EXEC (1 cycle) -> RESP; minimum issue interval is 3 cycles.
// Backpressure: instr_ready only in IDLE; the result is held in RESP until res_valid & res_ready.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [12:0] instr,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [3:0]  alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_data,
    output logic [1:0]  res_rd,
    output logic        res_zero,
    output logic        res_err,
    output logic [7:0]  instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOADI = 3'b101;

    state_t          state;
    logic [3:0][3:0] regs;

    // Fields of the offered instruction word, used on the accepting edge.
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [3:0] in_imm;

    // Only destination and legality need to survive into EXEC; operands are
    // read from the register file on the accepting edge straight into alu_a/alu_b.
    logic [1:0] exec_rd;
    logic       exec_illegal;
    logic [3:0] exec_result;

    assign in_op  = instr[12:10];
    assign in_rd  = instr[9:8];
    assign in_rs1 = instr[7:6];
    assign in_rs2 = instr[5:4];
    assign in_imm = instr[3:0];

    assign instr_ready = (state == IDLE);
    assign exec_result = exec_illegal ? 4'd0 : alu_out;

    // Control FSM with registered ALU drive, result capture, write-back and completion count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            regs         <= '0;
            exec_rd      <= 2'd0;
            exec_illegal <= 1'b0;
            alu_a        <= 4'd0;
            alu_b        <= 4'd0;
            alu_sel      <= 3'd0;
            res_valid    <= 1'b0;
            res_data     <= 4'd0;
            res_rd       <= 2'd0;
            res_zero     <= 1'b0;
            res_err      <= 1'b0;
            instr_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        exec_rd      <= in_rd;
                        exec_illegal <= (in_op[2:1] == 2'b11);
                        state        <= EXEC;
                        if (in_op < OP_LOADI) begin
                            // Previous write-back landed at least two edges ago, so the read is current.
                            alu_a   <= regs[in_rs1];
                            alu_b   <= regs[in_rs2];
                            alu_sel <= in_op;
                        end else if (in_op == OP_LOADI) begin
                            alu_a   <= 4'd0;
                            alu_b   <= in_imm;
                            alu_sel <= 3'b000;
                        end else begin
                            alu_a   <= 4'd0;
                            alu_b   <= 4'd0;
                            alu_sel <= 3'b000;
                        end
                    end
                end
                EXEC: begin
                    res_data  <= exec_result;
                    res_zero  <= (exec_result == 4'd0);
                    res_err   <= exec_illegal;
                    res_rd    <= exec_rd;
                    res_valid <= 1'b1;
                    if (!exec_illegal) begin
                        regs[exec_rd] <= alu_out;
                    end
                    alu_a   <= 4'd0;
                    alu_b   <= 4'd0;
                    alu_sel <= 3'd0;
                    state   <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        instr_count <= instr_count + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
